lbirow_msg_packer: RTL and testbench

//  Producer side of the Lbirow message interface. Accepts the message as a stream of

---
 rtl/lbirow_pkg.sv | 17 +
 rtl/lbirow_out_slot.sv | 36 +++
 rtl/lbirow_msg_packer.sv | 114 +++++++++++
 tb/tb_lbirow_msg_packer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbirow_pkg.sv
// Shared sizes and state encoding for the Lbirow message packer.
package lbirow_pkg;

  localparam int INPUTSIZE  = 840;
  localparam int CHUNK_W    = 16;
  localparam int NUM_CHUNKS = (INPUTSIZE + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_BITS   = NUM_CHUNKS * CHUNK_W - INPUTSIZE;
  // Number of meaningful bits carried by the final chunk of a message.
  localparam int LAST_W     = CHUNK_W - PAD_BITS;
  localparam int CNT_W      = 6;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/lbirow_out_slot.sv
// Output holding register: keeps the message stable until the consumer takes it.
module lbirow_out_slot
  import lbirow_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_load,
  input  logic [INPUTSIZE-1:0] i_data,
  input  logic                 i_rdy,
  output logic                 o_vld,
  output logic [INPUTSIZE-1:0] o_data,
  output logic                 o_free
);

  logic                 r_vld;
  logic [INPUTSIZE-1:0] r_data;

  // The slot can take a new message when empty or when it drains this cycle.
  assign o_free = !r_vld || i_rdy;
  assign o_vld  = r_vld;
  assign o_data = r_data;

  // Load wins over accept so a back-to-back transfer keeps vld high with new data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_data <= i_data;
    end else if (r_vld && i_rdy) begin
      r_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/lbirow_msg_packer.sv
// Lbirow producer: assembles CHUNK_W-bit chunks into an INPUTSIZE-bit message and
// hands it to a double-buffered output slot.
// Handshakes: a transfer happens on a rising clock edge where valid and ready are both
// high; valid must not depend on ready, and data is only meaningful while valid is high.
module lbirow_msg_packer
  import lbirow_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CHUNK_W-1:0]   chunk_in,
  input  logic                 chunk_vld,
  input  logic                 chunk_last,
  output logic                 chunk_rdy,
  output logic [INPUTSIZE-1:0] msg_out,
  output logic                 msgout_vld,
  input  logic                 msgout_rdy,
  output logic                 len_err,
  output state_t               dbg_state
);

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [INPUTSIZE-1:0] r_buf, w_buf_next, w_asm_msg, w_load_data;
  logic                 r_alive, r_len_err, w_len_err_next;
  logic                 w_hs, w_final, w_load, w_slot_free;

  assign chunk_rdy = r_alive && (r_state == FILL);
  assign w_hs      = chunk_vld && chunk_rdy;
  assign w_final   = (r_cnt == CNT_W'(NUM_CHUNKS - 1));
  assign len_err   = r_len_err;
  assign dbg_state = r_state;

  // Assembly buffer with the incoming chunk dropped into its lane; pad bits of the final chunk are discarded.
  always_comb begin
    w_asm_msg = r_buf;
    for (int k = 0; k < NUM_CHUNKS - 1; k++) begin
      if (r_cnt == CNT_W'(k)) w_asm_msg[k*CHUNK_W +: CHUNK_W] = chunk_in;
    end
    if (w_final) w_asm_msg[INPUTSIZE-1 -: LAST_W] = chunk_in[LAST_W-1:0];
  end

  // Next-state, counter, buffer and slot-load decisions.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_buf_next     = r_buf;
    w_load         = 1'b0;
    w_load_data    = w_asm_msg;
    w_len_err_next = 1'b0;
    case (r_state)
      FILL: begin
        if (w_hs) begin
          if (w_final) begin
            w_cnt_next     = '0;
            w_len_err_next = !chunk_last;
            if (w_slot_free) begin
              w_load     = 1'b1;
              w_buf_next = '0;
            end else begin
              w_buf_next   = w_asm_msg;
              w_state_next = STALL;
            end
          end else if (chunk_last) begin
            // Early terminator: throw the partial message away.
            w_cnt_next     = '0;
            w_buf_next     = '0;
            w_len_err_next = 1'b1;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
            w_buf_next = w_asm_msg;
          end
        end
      end
      STALL: begin
        if (w_slot_free) begin
          w_load       = 1'b1;
          w_load_data  = r_buf;
          w_buf_next   = '0;
          w_state_next = FILL;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  // State, counter, assembly buffer and error pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= FILL;
      r_cnt     <= '0;
      r_buf     <= '0;
      r_alive   <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_buf     <= w_buf_next;
      r_alive   <= 1'b1;
      r_len_err <= w_len_err_next;
    end
  end

  lbirow_out_slot u_out_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_rdy   (msgout_rdy),
    .o_vld   (msgout_vld),
    .o_data  (msg_out),
    .o_free  (w_slot_free)
  );

endmodule

// File: tb/tb_lbirow_msg_packer.sv
// Bench for lbirow_msg_packer: directed scenarios followed by randomized traffic,
// checked against a chunk-list reference model and an expected-message queue.
module tb_lbirow_msg_packer;
  import lbirow_pkg::*;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [CHUNK_W-1:0]   chunk_in;
  logic                 chunk_vld, chunk_last, chunk_rdy;
  logic [INPUTSIZE-1:0] msg_out;
  logic                 msgout_vld, msgout_rdy, len_err;
  state_t               dbg_state;

  always #5 clk = ~clk;

  lbirow_msg_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chunk_in   (chunk_in),
    .chunk_vld  (chunk_vld),
    .chunk_last (chunk_last),
    .chunk_rdy  (chunk_rdy),
    .msg_out    (msg_out),
    .msgout_vld (msgout_vld),
    .msgout_rdy (msgout_rdy),
    .len_err    (len_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int exp_err = 0;
  int got_err = 0;
  int exp_msgs = 0;
  int n_msgs = 0;
  logic [INPUTSIZE-1:0] exp_q[$];
  logic [CHUNK_W-1:0]   m_chunks[$];
  logic [INPUTSIZE-1:0] m_last;
  logic [INPUTSIZE-1:0] s1_msg;
  logic [INPUTSIZE-1:0] hold_msg;
  logic                 prev_hold = 1'b0;
  logic [INPUTSIZE-1:0] prev_msg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_msg(input string tag, input logic [INPUTSIZE-1:0] obs,
                         input logic [INPUTSIZE-1:0] exp);
    logic [NUM_CHUNKS*CHUNK_W-1:0] oa, ea;
    int idx;
    checks++;
    assert (obs === exp) else begin
      errors++;
      oa = '0; ea = '0;
      oa[INPUTSIZE-1:0] = obs;
      ea[INPUTSIZE-1:0] = exp;
      idx = 0;
      for (int k = NUM_CHUNKS - 1; k >= 0; k--)
        if (oa[k*CHUNK_W +: CHUNK_W] !== ea[k*CHUNK_W +: CHUNK_W]) idx = k;
      $error("FAIL %s chunk=%0d observed=%h expected=%h", tag, idx,
             oa[idx*CHUNK_W +: CHUNK_W], ea[idx*CHUNK_W +: CHUNK_W]);
    end
  endtask

  // Reference model: a message is the list of accepted chunks; a terminator before
  // the last position aborts it, and the NUM_CHUNKS-th chunk completes it.
  task automatic model_accept(input logic [CHUNK_W-1:0] d, input logic last);
    logic [NUM_CHUNKS*CHUNK_W-1:0] full;
    if (last && m_chunks.size() < NUM_CHUNKS - 1) begin
      m_chunks.delete();
      exp_err++;
    end else begin
      m_chunks.push_back(d);
      if (m_chunks.size() == NUM_CHUNKS) begin
        full = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) full[k*CHUNK_W +: CHUNK_W] = m_chunks[k];
        m_last = full[INPUTSIZE-1:0];
        exp_q.push_back(m_last);
        exp_msgs++;
        if (!last) exp_err++;
        m_chunks.delete();
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_chunk(input logic [CHUNK_W-1:0] d, input logic last, input bit rnd_rdy);
    int   budget;
    logic hs;
    budget = 0;
    chunk_in   = d;
    chunk_last = last;
    chunk_vld  = 1'b1;
    do begin
      if (rnd_rdy) msgout_rdy = 1'($urandom_range(0, 1));
      hs = chunk_rdy;
      @(posedge clk);
      #1;
      budget++;
    end while (!hs && budget < 300);
    chunk_vld  = 1'b0;
    chunk_last = 1'b0;
    chk("chunk_accept", hs, 1'b1);
    if (hs) model_accept(d, last);
  endtask

  task automatic send_inc_msg(input logic [CHUNK_W-1:0] base);
    for (int k = 0; k < NUM_CHUNKS; k++)
      send_chunk(base + CHUNK_W'(k), k == NUM_CHUNKS - 1, 1'b0);
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_vld", msgout_vld, 1'b1);
        chk_msg("hold_data", msg_out, prev_msg);
      end
      if (msgout_vld && msgout_rdy) begin
        chk("msg_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk_msg("msg_data", msg_out, exp_q.pop_front());
        n_msgs++;
      end
      if (len_err) got_err++;
      prev_hold <= msgout_vld && !msgout_rdy;
      prev_msg  <= msg_out;
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [INPUTSIZE-1:0] a5_msg;
    logic [CHUNK_W-1:0]   d;
    int budget, mode, early_k;

    reset_n    = 1'b0;
    chunk_in   = '0;
    chunk_vld  = 1'b0;
    chunk_last = 1'b0;
    msgout_rdy = 1'b1;
    tick(2);
    chk("rst_vld", msgout_vld, 1'b0);
    chk("rst_rdy", chunk_rdy, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    chk_msg("rst_msg", msg_out, '0);
    reset_n = 1'b1;
    tick(1);
    chk("rdy_after_rst", chunk_rdy, 1'b1);

    // 1: incrementing message, consumer always ready
    for (int k = 0; k < NUM_CHUNKS - 1; k++) send_chunk(16'h0001 + 16'(k), 1'b0, 1'b0);
    chk("s1_no_early_vld", msgout_vld, 1'b0);
    send_chunk(16'h0035, 1'b1, 1'b0);
    s1_msg = m_last;
    chk("s1_vld", msgout_vld, 1'b1);
    chk("s1_lo", msg_out[15:0], 16'h0001);
    chk("s1_hi", msg_out[INPUTSIZE-1 -: 8], 8'h35);
    chk("s1_len_err", len_err, 1'b0);
    tick(2);

    // 2: consumer blocked, two messages -> stall
    msgout_rdy = 1'b0;
    send_inc_msg(16'h1000);
    hold_msg = m_last;
    send_inc_msg(16'h2000);
    chk("s2_rdy_low", chunk_rdy, 1'b0);
    chk("s2_state", dbg_state, STALL);
    chk_msg("s2_msg1_held", msg_out, hold_msg);
    tick(3);
    chk("s2_still_stalled", chunk_rdy, 1'b0);
    msgout_rdy = 1'b1;
    tick(1);
    msgout_rdy = 1'b0;
    chk("s2_vld", msgout_vld, 1'b1);
    chk_msg("s2_msg2", msg_out, m_last);
    chk("s2_rdy_back", chunk_rdy, 1'b1);
    tick(2);
    msgout_rdy = 1'b1;
    tick(2);

    // 3: early last, then a clean all-A5 message
    for (int k = 0; k <= 10; k++) send_chunk(16'h3000 + 16'(k), k == 10, 1'b0);
    chk("s3_len_err", len_err, 1'b1);
    chk("s3_no_vld", msgout_vld, 1'b0);
    tick(1);
    chk("s3_len_err_pulse", len_err, 1'b0);
    for (int k = 0; k < NUM_CHUNKS; k++) send_chunk(16'hA5A5, k == NUM_CHUNKS - 1, 1'b0);
    a5_msg = {105{8'hA5}};
    chk_msg("s3_a5_msg", msg_out, a5_msg);
    tick(2);

    // 4: missing last
    for (int k = 0; k < NUM_CHUNKS; k++) send_chunk(16'($urandom), 1'b0, 1'b0);
    chk("s4_vld", msgout_vld, 1'b1);
    chk("s4_len_err", len_err, 1'b1);
    tick(1);
    chk("s4_len_err_pulse", len_err, 1'b0);
    tick(1);

    // 5: pad bits of the final chunk are discarded
    for (int k = 0; k < NUM_CHUNKS - 1; k++) send_chunk(16'($urandom), 1'b0, 1'b0);
    send_chunk(16'hFF00, 1'b1, 1'b0);
    chk("s5_top_00", msg_out[INPUTSIZE-1 -: 8], 8'h00);
    for (int k = 0; k < NUM_CHUNKS - 1; k++) send_chunk(16'($urandom), 1'b0, 1'b0);
    send_chunk(16'h00FF, 1'b1, 1'b0);
    chk("s5_top_ff", msg_out[INPUTSIZE-1 -: 8], 8'hFF);
    tick(2);

    // 6: reset in mid-message, then scenario 1 again
    for (int k = 0; k <= 30; k++) send_chunk(16'h0001 + 16'(k), 1'b0, 1'b0);
    reset_n = 1'b0;
    exp_msgs = exp_msgs - exp_q.size();
    exp_q.delete();
    m_chunks.delete();
    #1;
    chk("s6_rst_vld", msgout_vld, 1'b0);
    chk("s6_rst_rdy", chunk_rdy, 1'b0);
    chk("s6_rst_len_err", len_err, 1'b0);
    chk_msg("s6_rst_msg", msg_out, '0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    send_inc_msg(16'h0001);
    chk("s6_vld", msgout_vld, 1'b1);
    chk_msg("s6_repeat_s1", msg_out, s1_msg);
    tick(2);

    // random traffic: back-pressure, gaps, occasional length errors
    for (int m = 0; m < 30; m++) begin
      mode    = $urandom_range(0, 9);
      early_k = $urandom_range(0, NUM_CHUNKS - 2);
      for (int k = 0; k < NUM_CHUNKS; k++) begin
        d = 16'($urandom);
        if (mode == 0 && k == early_k) begin
          send_chunk(d, 1'b1, 1'b1);
          break;
        end
        send_chunk(d, (k == NUM_CHUNKS - 1) && (mode != 1), 1'b1);
        if ($urandom_range(0, 7) == 0) begin
          msgout_rdy = 1'($urandom_range(0, 1));
          tick($urandom_range(1, 2));
        end
      end
    end
    msgout_rdy = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      tick(1);
      budget++;
    end
    tick(3);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_vld_low", msgout_vld, 1'b0);
    chk("msg_total", n_msgs, exp_msgs);
    chk("len_err_total", got_err, exp_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
